// File: rtl/yconf_loader_if.sv
// rtl/yconf_loader_if.sv - row-in / readback-out handshake bundle for yconf_loader
interface yconf_loader_if #(
    parameter int BLOCKWIDTH = 8
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [BLOCKWIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [BLOCKWIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/yconf_loader.sv
// rtl/yconf_loader.sv - drives a yellow-cell configuration chain (confclk/cbitin) and captures cbitout readback
module yconf_loader #(
    parameter int BLOCKWIDTH = 8,
    parameter int CHAINLEN   = 24,
    parameter int CLRCYC     = 4,
    parameter int HICYC      = 2,
    parameter int LOCYC      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  clear_first,
    output logic                  busy,
    output logic                  done,
    yconf_loader_if.slave         io,
    output logic                  blk_reset,
    output logic                  confclk,
    output logic [BLOCKWIDTH-1:0] cbitin,
    input  logic [BLOCKWIDTH-1:0] cbitout
);
    localparam int TMAX = (CLRCYC > HICYC) ? ((CLRCYC > LOCYC) ? CLRCYC : LOCYC)
                                           : ((HICYC > LOCYC) ? HICYC : LOCYC);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(CHAINLEN + 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, WAIT_ROW, SETUP, HIGH, LOW, PUSH, DONE
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [RW-1:0]         rowcnt_q, rowcnt_d;
    logic [BLOCKWIDTH-1:0] cbitin_q, cbitin_d;
    logic [BLOCKWIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  confclk_q, confclk_d;
    logic                  blk_reset_q, blk_reset_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            rowcnt_q    <= '0;
            cbitin_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            confclk_q   <= 1'b0;
            blk_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rowcnt_q    <= rowcnt_d;
            cbitin_q    <= cbitin_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            confclk_q   <= confclk_d;
            blk_reset_q <= blk_reset_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        rowcnt_d    = rowcnt_q;
        cbitin_d    = cbitin_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rowcnt_d = '0;
                    timer_d  = '0;
                    state_d  = clear_first ? CLEAR : WAIT_ROW;
                end
            end
            // CLRCYC cycles with blk_reset high, then one quiet cycle
            CLEAR: begin
                if (timer_q == TW'(CLRCYC)) begin
                    timer_d = '0;
                    state_d = WAIT_ROW;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_ROW: begin
                if (io.in_valid) begin
                    cbitin_d = io.in_data;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                timer_d = '0;
                state_d = HIGH;
            end
            HIGH: begin
                if (timer_q == TW'(HICYC - 1)) begin
                    timer_d = '0;
                    state_d = LOW;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            LOW: begin
                if (timer_q == TW'(LOCYC - 1)) begin
                    timer_d     = '0;
                    out_data_d  = cbitout;
                    out_valid_d = 1'b1;
                    state_d     = PUSH;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            // no further strobe until the host has taken the readback row
            PUSH: begin
                if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    rowcnt_d    = rowcnt_q + 1'b1;
                    state_d     = (rowcnt_d == RW'(CHAINLEN)) ? DONE : WAIT_ROW;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        confclk_d   = (state_d == HIGH);
        blk_reset_d = (state_d == CLEAR) && (timer_d < TW'(CLRCYC));
    end

    assign busy         = (state_q != IDLE) && (state_q != DONE);
    assign done         = (state_q == DONE);
    assign io.in_ready  = (state_q == WAIT_ROW);
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign blk_reset    = blk_reset_q;
    assign confclk      = confclk_q;
    assign cbitin       = cbitin_q;
endmodule

// File: tb/tb_yconf_loader.sv
// tb/tb_yconf_loader.sv - self-checking bench for yconf_loader with a behavioural chain model
module tb_yconf_loader;
    localparam int BW  = 8;
    localparam int CL  = 24;
    localparam int CLR = 4;
    localparam int HI  = 2;
    localparam int LO  = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          clear_first = 1'b0;
    logic          busy, done, blk_reset, confclk;
    logic [BW-1:0] cbitin, cbitout;

    yconf_loader_if #(.BLOCKWIDTH(BW)) io ();

    yconf_loader #(.BLOCKWIDTH(BW), .CHAINLEN(CL), .CLRCYC(CLR), .HICYC(HI), .LOCYC(LO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .clear_first(clear_first),
        .busy(busy), .done(done), .io(io.slave), .blk_reset(blk_reset),
        .confclk(confclk), .cbitin(cbitin), .cbitout(cbitout)
    );

    always #5 clk = ~clk;

    // yblock stand-in: CL-deep chain plus an output stage shifting on confclk
    logic [BW-1:0] chain [CL];
    logic [BW-1:0] blk_out;
    always @(posedge confclk or posedge blk_reset) begin
        if (blk_reset) begin
            for (int i = 0; i < CL; i++) chain[i] <= '0;
            blk_out <= '0;
        end else begin
            blk_out <= chain[CL-1];
            for (int i = CL-1; i > 0; i--) chain[i] <= chain[i-1];
            chain[0] <= cbitin;
        end
    end
    assign cbitout = blk_out;

    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0, bad_width = 0, hi_len = 0, done_cnt = 0, bad_gap = 0, bad_cb = 0;
    logic [BW-1:0] refq[$];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (io.in_ready && confclk) bad_gap++;
        if (confclk) hi_len++;
        else if (hi_len != 0) begin
            strobe_cnt++;
            if (hi_len != HI) bad_width++;
            hi_len = 0;
        end
    end

    logic [BW-1:0] cb_prev = '0;
    logic          acc;
    always @(posedge clk) begin
        acc = io.in_valid && io.in_ready;
        @(negedge clk);
        if (cbitin !== cb_prev && !acc) bad_cb++;
        cb_prev = cbitin;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: rows base+i; mode 1: random rows, random gaps and stalls
    task automatic load(input bit clr, input int mode, input logic [BW-1:0] base,
                        input int gap, input int stall_first, input bit poke_start);
        int s0, d0, w0, g0, c0, cnt, lat, gp, st;
        logic [BW-1:0] row, expv;
        bit ok;
        s0 = strobe_cnt; d0 = done_cnt; w0 = bad_width; g0 = bad_gap; c0 = bad_cb;
        start = 1'b1; clear_first = clr;
        @(negedge clk);
        start = 1'b0; clear_first = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        if (clr) begin
            refq.delete();
            for (int i = 0; i < CL; i++) refq.push_back('0);
            cnt = 0;
            while (blk_reset && cnt < 20) begin cnt++; @(negedge clk); end
            check("clear_len", cnt, CLR);
            check("clear_gap_no_ready", {31'd0, io.in_ready}, 32'd0);
            @(negedge clk);
        end
        for (int r = 0; r < CL; r++) begin
            cnt = 0;
            while (!io.in_ready && cnt < 100) begin cnt++; @(negedge clk); end
            if (cnt >= 100) check("wait_ready_timeout", cnt, 0);
            row = (mode == 0) ? BW'(base + BW'(r)) : BW'($urandom);
            gp  = (mode == 0) ? gap : int'($urandom_range(0, 3));
            st  = (mode == 0) ? ((r == 0) ? stall_first : 0) : int'($urandom_range(0, 3));
            for (int g = 0; g < gp; g++) @(negedge clk);
            io.in_valid = 1'b1; io.in_data = row;
            if (poke_start && r == 5) start = 1'b1;
            @(negedge clk);
            io.in_valid = 1'b0; io.in_data = $urandom; start = 1'b0;
            refq.push_back(row);
            expv = refq.pop_front();
            lat = 0;
            while (!io.out_valid && lat < 50) begin @(negedge clk); lat++; end
            check("latency", lat, 1 + HI + LO);
            check("readback", {24'd0, io.out_data}, {24'd0, expv});
            if (st > 0) begin
                io.out_ready = 1'b0;
                ok = 1'b1;
                for (int s = 0; s < st; s++) begin
                    @(negedge clk);
                    ok &= (io.out_data === expv) && !confclk && !io.in_ready && io.out_valid;
                end
                check("stall_hold", {31'd0, ok}, 32'd1);
                io.out_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("done_pulse", {31'd0, done}, 32'd1);
        if (poke_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("idle_after", {30'd0, busy, io.in_ready}, 32'd0);
        check("strobes", strobe_cnt - s0, CL);
        check("done_count", done_cnt - d0, 1);
        check("strobe_width", bad_width - w0, 0);
        check("confclk_in_wait", bad_gap - g0, 0);
        check("cbitin_stable", bad_cb - c0, 0);
    endtask

    initial begin
        int cnt;
        io.in_valid = 1'b0; io.in_data = '0; io.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", {24'd0, busy, done, io.in_ready, io.out_valid, blk_reset, confclk,
              |cbitin, |io.out_data}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // abort a load while confclk is high
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        io.in_valid = 1'b1; io.in_data = 8'h5A;
        @(negedge clk);
        io.in_valid = 1'b0;
        cnt = 0;
        while (!confclk && cnt < 20) begin cnt++; @(negedge clk); end
        check("reached_high", {31'd0, confclk}, 32'd1);
        #2 reset_n = 1'b0;
        #1 check("async_reset", {29'd0, confclk, busy, io.out_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {30'd0, busy, io.in_ready}, 32'd0);

        load(1'b1, 0, 8'h01, 0, 10, 1'b0);
        load(1'b0, 0, 8'hA0, 3, 0, 1'b1);
        load(1'b0, 1, 8'h00, 0, 0, 1'b0);
        load(1'b1, 1, 8'h00, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
